// File: rtl/hazard_ctrl_if.sv
// Decode/execute/memory status into the hazard controller and per-stage stall/flush back out.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(parameter int REG_W = 9);
  logic [REG_W-1:0] dec_rs1_in;
  logic             dec_rs1_read_in;
  logic [REG_W-1:0] dec_rs2_in;
  logic             dec_rs2_read_in;
  logic             dec_fence_in;
  logic             ex_valid_in;
  logic             ex_mem_read_in;
  logic [REG_W-1:0] ex_rd_in;
  logic             ex_rd_write_in;
  logic             ex_mispredict_in;
  logic             icache_busy_in;
  logic             mem_busy_in;
  logic             store_buf_empty_in;
  logic             fetch_stall_out;
  logic             fetch_flush_out;
  logic             decode_stall_out;
  logic             decode_flush_out;
  logic             execute_stall_out;
  logic             mem_stall_out;

  modport master (
    output dec_rs1_in, dec_rs1_read_in, dec_rs2_in, dec_rs2_read_in, dec_fence_in,
           ex_valid_in, ex_mem_read_in, ex_rd_in, ex_rd_write_in, ex_mispredict_in,
           icache_busy_in, mem_busy_in, store_buf_empty_in,
    input  fetch_stall_out, fetch_flush_out, decode_stall_out, decode_flush_out,
           execute_stall_out, mem_stall_out
  );

  modport slave (
    input  dec_rs1_in, dec_rs1_read_in, dec_rs2_in, dec_rs2_read_in, dec_fence_in,
           ex_valid_in, ex_mem_read_in, ex_rd_in, ex_rd_write_in, ex_mispredict_in,
           icache_busy_in, mem_busy_in, store_buf_empty_in,
    output fetch_stall_out, fetch_flush_out, decode_stall_out, decode_flush_out,
           execute_stall_out, mem_stall_out
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, mispredict flushes, memory freeze, FENCE drain.
// Optional perf counters (stall_cycles_out, flush_count_out) when HAZARD_PERF_EN is defined.
//
// state      | meaning
// RUN        | normal issue, hazards checked every cycle
// FENCE_WAIT | fence held in decode until store buffer has been empty FENCE_SETTLE cycles
// FENCE_GO   | fence released into execute (held while a load-use hazard exists)
module hazard_ctrl #(
  parameter int REG_W        = 9,
  parameter int FENCE_SETTLE = 2,
  parameter int PERF_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  hazard_ctrl_if.slave        hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]   stall_cycles_out,
  output logic [PERF_W-1:0]   flush_count_out
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FENCE_WAIT = 2'd1,
    FENCE_GO   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE = 4'(FENCE_SETTLE);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt, settle_nxt;
  logic       load_use;
  logic       mp_flush;
  logic       f_stall, f_flush, d_stall, d_flush, e_stall, m_stall;

  assign load_use = hz.ex_valid_in && hz.ex_mem_read_in && hz.ex_rd_write_in &&
                    (hz.ex_rd_in != '0) &&
                    ((hz.dec_rs1_read_in && (hz.dec_rs1_in == hz.ex_rd_in)) ||
                     (hz.dec_rs2_read_in && (hz.dec_rs2_in == hz.ex_rd_in)));

  always_comb begin
    f_stall    = 1'b0;
    f_flush    = 1'b0;
    d_stall    = 1'b0;
    d_flush    = 1'b0;
    e_stall    = 1'b0;
    m_stall    = 1'b0;
    mp_flush   = 1'b0;
    state_nxt  = state;
    settle_nxt = settle_cnt;
    if (reset) begin
      f_flush = 1'b1;
      d_flush = 1'b1;
    end else if (hz.mem_busy_in) begin
      // Execute keeps the branch, so a pending mispredict re-presents once memory frees up.
      f_stall = 1'b1;
      d_stall = 1'b1;
      e_stall = 1'b1;
      m_stall = 1'b1;
    end else if (hz.ex_mispredict_in) begin
      f_flush    = 1'b1;
      d_flush    = 1'b1;
      mp_flush   = 1'b1;
      state_nxt  = RUN;
      settle_nxt = '0;
    end else begin
      case (state)
        FENCE_WAIT: begin
          f_stall = 1'b1;
          d_flush = 1'b1;
          if (settle_cnt == SETTLE) begin
            state_nxt  = FENCE_GO;
            settle_nxt = '0;
          end else if (hz.store_buf_empty_in) begin
            settle_nxt = settle_cnt + 4'd1;
          end else begin
            settle_nxt = '0;
          end
        end
        FENCE_GO: begin
          if (load_use) begin
            f_stall = 1'b1;
            d_flush = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (hz.dec_fence_in && !hz.icache_busy_in) begin
            f_stall    = 1'b1;
            d_flush    = 1'b1;
            state_nxt  = FENCE_WAIT;
            settle_nxt = '0;
          end else if (load_use) begin
            f_stall = 1'b1;
            d_flush = 1'b1;
          end else if (hz.icache_busy_in) begin
            d_flush = 1'b1;
          end
        end
        default: begin
          state_nxt  = RUN;
          settle_nxt = '0;
        end
      endcase
    end
  end

  assign hz.fetch_stall_out   = f_stall;
  assign hz.fetch_flush_out   = f_flush;
  assign hz.decode_stall_out  = d_stall;
  assign hz.decode_flush_out  = d_flush;
  assign hz.execute_stall_out = e_stall;
  assign hz.mem_stall_out     = m_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_out <= '0;
      flush_count_out  <= '0;
    end else begin
      if (f_stall)  stall_cycles_out <= stall_cycles_out + PERF_W'(1);
      if (mp_flush) flush_count_out  <= flush_count_out + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus queues expected stall/flush vectors,
// a negedge monitor pops and compares them (and the perf counters when HAZARD_PERF_EN).
module tb_hazard_ctrl;
  localparam int REG_W  = 9;
  localparam int PERF_W = 32;

  // bit order: fetch_stall fetch_flush decode_stall decode_flush execute_stall mem_stall
  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_FLSH = 6'b010100;
  localparam logic [5:0] E_BUBL = 6'b100100;
  localparam logic [5:0] E_ICB  = 6'b000100;
  localparam logic [5:0] E_MEM  = 6'b101011;

  typedef struct {
    logic [5:0] ctl;
    bit         rst;
    string      name;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t q[$];

  hazard_ctrl_if #(.REG_W(REG_W)) hz ();

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;
  logic [PERF_W-1:0] m_stall;
  logic [PERF_W-1:0] m_flush;
`endif

  hazard_ctrl #(.REG_W(REG_W), .FENCE_SETTLE(2), .PERF_W(PERF_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles_out (stall_cycles),
    .flush_count_out  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t       e;
    logic [5:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {hz.fetch_stall_out, hz.fetch_flush_out, hz.decode_stall_out,
             hz.decode_flush_out, hz.execute_stall_out, hz.mem_stall_out};
      total++;
      if (act !== e.ctl) begin
        bad++;
        $display("FAIL %s: outputs got %b expected %b", e.name, act, e.ctl);
      end
`ifdef HAZARD_PERF_EN
      total++;
      if (stall_cycles !== m_stall || flush_count !== m_flush) begin
        bad++;
        $display("FAIL %s perf: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, stall_cycles, flush_count, m_stall, m_flush);
      end
      if (e.rst) begin
        m_stall = '0;
        m_flush = '0;
      end else begin
        if (e.ctl[5]) m_stall = m_stall + 1;
        if (e.ctl[4]) m_flush = m_flush + 1;
      end
`endif
    end
  end

  task automatic idle();
    hz.dec_rs1_in         = '0;
    hz.dec_rs1_read_in    = 1'b0;
    hz.dec_rs2_in         = '0;
    hz.dec_rs2_read_in    = 1'b0;
    hz.dec_fence_in       = 1'b0;
    hz.ex_valid_in        = 1'b0;
    hz.ex_mem_read_in     = 1'b0;
    hz.ex_rd_in           = '0;
    hz.ex_rd_write_in     = 1'b0;
    hz.ex_mispredict_in   = 1'b0;
    hz.icache_busy_in     = 1'b0;
    hz.mem_busy_in        = 1'b0;
    hz.store_buf_empty_in = 1'b1;
  endtask

  task automatic ex_load(input logic [REG_W-1:0] rd);
    hz.ex_valid_in    = 1'b1;
    hz.ex_mem_read_in = 1'b1;
    hz.ex_rd_write_in = 1'b1;
    hz.ex_rd_in       = rd;
  endtask

  task automatic use_rs1(input logic [REG_W-1:0] r);
    hz.dec_rs1_in      = r;
    hz.dec_rs1_read_in = 1'b1;
  endtask

  task automatic step(input string nm, input logic [5:0] exp_ctl);
    exp_t e;
    e.ctl  = exp_ctl;
    e.rst  = reset;
    e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
`ifdef HAZARD_PERF_EN
    m_stall = '0;
    m_flush = '0;
`endif
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step("reset0", E_FLSH);
    step("reset1", E_FLSH);
    reset = 1'b0;
    step("idle", E_NONE);

    ex_load(9'd5); use_rs1(9'd5);
    step("lu_rs1", E_BUBL);
    idle();
    step("lu_clear", E_NONE);

    ex_load(9'd7); hz.dec_rs2_in = 9'd7; hz.dec_rs2_read_in = 1'b1;
    step("lu_rs2", E_BUBL);
    idle(); ex_load(9'd0); use_rs1(9'd0);
    step("lu_rd0", E_NONE);
    idle(); ex_load(9'd5); hz.dec_rs2_in = 9'd5;
    step("lu_rs2_noread", E_NONE);
    idle(); ex_load(9'd5); use_rs1(9'd5); hz.ex_valid_in = 1'b0;
    step("lu_ex_invalid", E_NONE);
    idle(); ex_load(9'd5); use_rs1(9'd5); hz.ex_rd_write_in = 1'b0;
    step("lu_no_write", E_NONE);
    idle(); ex_load(9'd5); use_rs1(9'd4);
    step("lu_diff_reg", E_NONE);

    idle(); hz.icache_busy_in = 1'b1;
    step("icache_busy", E_ICB);
    ex_load(9'd3); use_rs1(9'd3);
    step("icache_lu", E_BUBL);
    idle(); hz.icache_busy_in = 1'b1; hz.dec_fence_in = 1'b1;
    step("fence_icache", E_ICB);

    // fence: store buffer busy 4 cycles then empty -> 4+2+1 stall cycles
    idle(); hz.dec_fence_in = 1'b1; hz.store_buf_empty_in = 1'b0;
    step("fence_enter", E_BUBL);
    ex_load(9'd6); use_rs1(9'd6);
    step("fence_wait_sb0", E_BUBL);
    step("fence_wait_sb0", E_BUBL);
    step("fence_wait_sb0", E_BUBL);
    hz.store_buf_empty_in = 1'b1;
    step("fence_wait_sb1", E_BUBL);
    step("fence_wait_sb1", E_BUBL);
    step("fence_wait_done", E_BUBL);
    step("fence_go_lu", E_BUBL);
    idle();
    step("fence_go", E_NONE);
    hz.icache_busy_in = 1'b1;
    step("after_fence_run", E_ICB);

    // settle count clears when store buffer refills
    idle(); hz.dec_fence_in = 1'b1;
    step("fence2_enter", E_BUBL);
    hz.dec_fence_in = 1'b0;
    step("fence2_cnt1", E_BUBL);
    hz.store_buf_empty_in = 1'b0;
    step("fence2_clear", E_BUBL);
    hz.store_buf_empty_in = 1'b1;
    step("fence2_cnt1b", E_BUBL);
    step("fence2_cnt2", E_BUBL);
    step("fence2_done", E_BUBL);
    step("fence2_go", E_NONE);
    step("fence2_run", E_NONE);

    // mispredict during FENCE_WAIT
    hz.dec_fence_in = 1'b1; hz.store_buf_empty_in = 1'b0;
    step("fence3_enter", E_BUBL);
    hz.dec_fence_in = 1'b0;
    step("fence3_wait", E_BUBL);
    hz.ex_mispredict_in = 1'b1;
    step("fence3_mispredict", E_FLSH);
    idle(); hz.store_buf_empty_in = 1'b0;
    step("fence3_run", E_NONE);

    // memory freeze defers mispredict
    idle(); hz.mem_busy_in = 1'b1; hz.ex_mispredict_in = 1'b1;
    step("mem_busy0", E_MEM);
    step("mem_busy1", E_MEM);
    step("mem_busy2", E_MEM);
    hz.mem_busy_in = 1'b0;
    step("mispredict_after_mem", E_FLSH);
    idle(); hz.mem_busy_in = 1'b1; ex_load(9'd2); use_rs1(9'd2);
    step("mem_busy_lu", E_MEM);
    idle();
    step("idle2", E_NONE);

    // reset mid-fence
    hz.dec_fence_in = 1'b1;
    step("fence4_enter", E_BUBL);
    hz.dec_fence_in = 1'b0; hz.store_buf_empty_in = 1'b0;
    step("fence4_wait", E_BUBL);
    reset = 1'b1;
    step("fence4_reset", E_FLSH);
    reset = 1'b0; hz.store_buf_empty_in = 1'b0;
    step("fence4_after_reset", E_NONE);
    idle();
    step("final_idle", E_NONE);

    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: queue left %0d expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
